// File: rtl/ballot_pkg.sv
// Shared definitions for the ballot capture block: candidate count, tally
// width, FSM state encoding and a press-count helper.
package ballot_pkg;

   localparam int NUM_CAND = 4;
   localparam int VOTE_W   = 8;

   typedef enum logic [1:0] {
      WAIT_REL = 2'd0,
      ARMED    = 2'd1,
      CAST     = 2'd2,
      LOCKOUT  = 2'd3
   } ballot_state_t;

   // Number of debounced buttons currently held.
   function automatic logic [2:0] press_count(input logic [NUM_CAND-1:0] lvl);
      logic [2:0] n;
      n = '0;
      for (int i = 0; i < NUM_CAND; i++) begin
         n = n + {2'b00, lvl[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Single-button debouncer: the output level follows the raw input only after
// the raw input has disagreed with it on DEBOUNCE_CYCLES consecutive edges.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_raw,
   output logic level
);

   localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [CNT_W-1:0] cnt;

   // Count consecutive disagreeing samples; any agreeing sample restarts the run.
   always_ff @(posedge clk) begin
      if (reset) begin
         level <= 1'b0;
         cnt   <= '0;
      end else if (btn_raw != level) begin
         if (cnt == LAST) begin
            level <= btn_raw;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end else begin
         cnt <= '0;
      end
   end

endmodule

// File: rtl/ballot_capture.sv
// Voting-machine capture block: debounces four candidate buttons, accepts a
// single clean press as one vote, rejects multi-presses, then locks out.
// Build option: BALLOT_SATURATE_EN makes tallies stick at 255 instead of wrapping.
//
// state    | meaning
// WAIT_REL | waiting for all buttons released (and voting mode)
// ARMED    | ready to accept exactly one pressed button
// CAST     | vote accepted this cycle, tally bumped, pulse high
// LOCKOUT  | LOCKOUT_CYCLES idle cycles, buttons ignored
module ballot_capture
   import ballot_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int LOCKOUT_CYCLES  = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              mode,
   input  logic [NUM_CAND-1:0] btn_raw,
   output logic [VOTE_W-1:0] cand1_vote,
   output logic [VOTE_W-1:0] cand2_vote,
   output logic [VOTE_W-1:0] cand3_vote,
   output logic [VOTE_W-1:0] cand4_vote,
   output logic              cand1_button_press,
   output logic              cand2_button_press,
   output logic              cand3_button_press,
   output logic              cand4_button_press,
   output logic              valid_vote_casted,
   output logic              vote_rejected
);

   localparam int LOCK_W = (LOCKOUT_CYCLES < 2) ? 1 : $clog2(LOCKOUT_CYCLES);
   localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(LOCKOUT_CYCLES - 1);

   logic [NUM_CAND-1:0] level;
   logic [VOTE_W-1:0]   tally [NUM_CAND];
   logic [LOCK_W-1:0]   lock_cnt;
   ballot_state_t       state, state_nxt;
   logic                cast_go, reject_go;

   function automatic logic [VOTE_W-1:0] bump(input logic [VOTE_W-1:0] v);
`ifdef BALLOT_SATURATE_EN
      return (v == '1) ? v : v + 1'b1;
`else
      return v + 1'b1;
`endif
   endfunction

   for (genvar g = 0; g < NUM_CAND; g++) begin : g_deb
      btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
         .clk     (clk),
         .reset   (reset),
         .btn_raw (btn_raw[g]),
         .level   (level[g])
      );
   end

   assign cand1_button_press = level[0];
   assign cand2_button_press = level[1];
   assign cand3_button_press = level[2];
   assign cand4_button_press = level[3];
   assign cand1_vote = tally[0];
   assign cand2_vote = tally[1];
   assign cand3_vote = tally[2];
   assign cand4_vote = tally[3];

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= WAIT_REL;
      else       state <= state_nxt;
   end

   // Next state plus accept/reject decisions; display mode always falls back to WAIT_REL.
   always_comb begin
      state_nxt = state;
      cast_go   = 1'b0;
      reject_go = 1'b0;
      if (mode) begin
         state_nxt = WAIT_REL;
      end else begin
         case (state)
            WAIT_REL: if (level == '0) state_nxt = ARMED;
            ARMED: begin
               if (press_count(level) == 3'd1) begin
                  state_nxt = CAST;
                  cast_go   = 1'b1;
               end else if (press_count(level) > 3'd1) begin
                  state_nxt = WAIT_REL;
                  reject_go = 1'b1;
               end
            end
            CAST:    state_nxt = LOCKOUT;
            LOCKOUT: if (lock_cnt == '0) state_nxt = WAIT_REL;
            default: state_nxt = WAIT_REL;
         endcase
      end
   end

   // Lockout down-counter, loaded while in CAST so LOCKOUT spans exactly LOCKOUT_CYCLES.
   always_ff @(posedge clk) begin
      if (reset)                                  lock_cnt <= '0;
      else if (state == CAST)                     lock_cnt <= LOCK_LOAD;
      else if (state == LOCKOUT && lock_cnt != '0) lock_cnt <= lock_cnt - 1'b1;
   end

   // Tallies and one-cycle pulses, registered on the decision edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_vote_casted <= 1'b0;
         vote_rejected     <= 1'b0;
         for (int i = 0; i < NUM_CAND; i++) tally[i] <= '0;
      end else begin
         valid_vote_casted <= cast_go;
         vote_rejected     <= reject_go;
         if (cast_go) begin
            for (int i = 0; i < NUM_CAND; i++) begin
               if (level[i]) tally[i] <= bump(tally[i]);
            end
         end
      end
   end

endmodule

// File: tb/tb_ballot_capture.sv
// Directed bench for ballot_capture with DEBOUNCE_CYCLES=4, LOCKOUT_CYCLES=10.
module tb_ballot_capture;

   logic       clk = 1'b0;
   logic       reset, mode;
   logic [3:0] btn_raw;
   logic [7:0] cand1_vote, cand2_vote, cand3_vote, cand4_vote;
   logic       cand1_button_press, cand2_button_press, cand3_button_press, cand4_button_press;
   logic       valid_vote_casted, vote_rejected;

   int total = 0;
   int bad   = 0;
   int n_valid = 0;
   int n_rej   = 0;
   int v0, r0;
   logic seen;

`ifdef BALLOT_SATURATE_EN
   localparam int WRAP_EXP = 255;
`else
   localparam int WRAP_EXP = 0;
`endif

   ballot_capture #(.DEBOUNCE_CYCLES(4), .LOCKOUT_CYCLES(10)) dut (
      .clk                (clk),
      .reset              (reset),
      .mode               (mode),
      .btn_raw            (btn_raw),
      .cand1_vote         (cand1_vote),
      .cand2_vote         (cand2_vote),
      .cand3_vote         (cand3_vote),
      .cand4_vote         (cand4_vote),
      .cand1_button_press (cand1_button_press),
      .cand2_button_press (cand2_button_press),
      .cand3_button_press (cand3_button_press),
      .cand4_button_press (cand4_button_press),
      .valid_vote_casted  (valid_vote_casted),
      .vote_rejected      (vote_rejected)
   );

   always #5 clk = ~clk;

   // Pulse counters sampled mid-cycle.
   always @(negedge clk) begin
      if (valid_vote_casted === 1'b1) n_valid++;
      if (vote_rejected === 1'b1)     n_rej++;
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic vote4();
      btn_raw = 4'b1000;
      tick(6);
      btn_raw = 4'b0000;
      tick(12);
   endtask

   initial begin
      reset = 1'b1; mode = 1'b0; btn_raw = 4'b0000;
      tick(2);
      check("rst_c1", cand1_vote, 0);
      check("rst_c2", cand2_vote, 0);
      check("rst_c3", cand3_vote, 0);
      check("rst_c4", cand4_vote, 0);
      check("rst_press", {cand4_button_press, cand3_button_press, cand2_button_press, cand1_button_press}, 0);
      check("rst_valid", valid_vote_casted, 0);
      check("rst_rej", vote_rejected, 0);

      // Clean press of candidate 2.
      reset = 1'b0; btn_raw = 4'b0010;
      v0 = n_valid;
      tick(4);
      check("c2_press_edge4", cand2_button_press, 1);
      check("c2_valid_edge4", valid_vote_casted, 0);
      tick(1);
      check("c2_valid_edge5", valid_vote_casted, 1);
      check("c2_tally_edge5", cand2_vote, 1);
      tick(1);
      check("c2_valid_edge6", valid_vote_casted, 0);
      tick(14);
      check("c2_pulses", n_valid - v0, 1);
      check("c2_other_c1", cand1_vote, 0);
      check("c2_other_c3", cand3_vote, 0);
      check("c2_other_c4", cand4_vote, 0);
      btn_raw = 4'b0000;
      tick(20);

      // Bouncing candidate 1 never settles.
      v0 = n_valid; seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
         btn_raw = 4'b0001;
         tick(1); seen |= cand1_button_press;
         tick(1); seen |= cand1_button_press;
         btn_raw = 4'b0000;
         tick(1); seen |= cand1_button_press;
         tick(1); seen |= cand1_button_press;
      end
      check("bounce_press", seen, 0);
      check("bounce_c1", cand1_vote, 0);
      check("bounce_pulses", n_valid - v0, 0);
      tick(6);

      // Multi-press rejection, then a clean candidate 3 vote.
      v0 = n_valid; r0 = n_rej;
      btn_raw = 4'b0101;
      tick(10);
      check("multi_rej", n_rej - r0, 1);
      check("multi_valid", n_valid - v0, 0);
      check("multi_c1", cand1_vote, 0);
      check("multi_c3", cand3_vote, 0);
      check("multi_c2", cand2_vote, 1);
      btn_raw = 4'b0000;
      tick(8);
      btn_raw = 4'b0100;
      tick(10);
      check("c3_tally", cand3_vote, 1);
      check("c3_pulses", n_valid - v0, 1);
      btn_raw = 4'b0000;
      tick(20);

      // Re-press during lockout must not produce a second vote.
      v0 = n_valid;
      btn_raw = 4'b0001;
      tick(5);
      check("c1_valid", valid_vote_casted, 1);
      check("c1_tally1", cand1_vote, 1);
      tick(1);
      btn_raw = 4'b0000;
      tick(5);
      check("lock_released", cand1_button_press, 0);
      btn_raw = 4'b0001;
      tick(20);
      check("lock_held_press", cand1_button_press, 1);
      check("lock_no_revote", cand1_vote, 1);
      check("lock_pulses", n_valid - v0, 1);
      btn_raw = 4'b0000;
      tick(8);
      btn_raw = 4'b0001;
      tick(10);
      check("c1_tally2", cand1_vote, 2);
      btn_raw = 4'b0000;
      tick(20);

      // Candidate 4 to 255, then one past.
      v0 = n_valid;
      repeat (255) vote4();
      check("c4_255", cand4_vote, 255);
      check("c4_255_pulses", n_valid - v0, 255);
      vote4();
      check("c4_overflow", cand4_vote, WRAP_EXP);
      check("c4_overflow_pulse", n_valid - v0, 256);
      check("c4_c1_kept", cand1_vote, 2);

      // Reset during CAST.
      btn_raw = 4'b0010;
      tick(5);
      check("cast_valid", valid_vote_casted, 1);
      check("cast_c2", cand2_vote, 2);
      reset = 1'b1;
      tick(1);
      check("rstcast_valid", valid_vote_casted, 0);
      check("rstcast_c1", cand1_vote, 0);
      check("rstcast_c2", cand2_vote, 0);
      check("rstcast_c3", cand3_vote, 0);
      check("rstcast_c4", cand4_vote, 0);
      check("rstcast_press", cand2_button_press, 0);

      // Display mode with button held: no votes.
      reset = 1'b0; mode = 1'b1;
      v0 = n_valid; r0 = n_rej;
      tick(20);
      check("mode1_press", cand2_button_press, 1);
      check("mode1_c2", cand2_vote, 0);
      check("mode1_pulses", n_valid - v0, 0);
      check("mode1_rej", n_rej - r0, 0);
      mode = 1'b0;
      tick(10);
      check("waitrel_c2", cand2_vote, 0);
      check("waitrel_pulses", n_valid - v0, 0);
      btn_raw = 4'b0000;
      tick(8);
      btn_raw = 4'b0010;
      tick(10);
      check("after_rst_c2", cand2_vote, 1);
      btn_raw = 4'b0000;
      tick(4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
